// File: rtl/llist_queue_ctrl_pkg.sv
// Shared types for the linked-list queue controller.
// FSM states, last-served operation and default widths.
package llq_pkg;

  localparam int LLQ_ID_W   = 10;
  localparam int LLQ_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ALLOC_WAIT,
    DEQ_RD,
    DEALLOC_WAIT
  } state_e;

  typedef enum logic {
    OP_DEQ,
    OP_ENQ
  } op_e;

endpackage

// File: rtl/llist_queue_ctrl_if.sv
// Queue-side and free-list-side handshakes of llist_queue_ctrl.
// slave is the controller view, master the requester/flist view.
interface llist_queue_ctrl_if
  import llq_pkg::*;
#(
  parameter int ID_W   = LLQ_ID_W,
  parameter int DATA_W = LLQ_DATA_W
);

  logic              init_done;
  logic              enq_req;
  logic [DATA_W-1:0] enq_data;
  logic              enq_ack;
  logic              deq_req;
  logic              deq_ack;
  logic [DATA_W-1:0] deq_data;
  logic              alloc_req;
  logic              alloc_ack;
  logic [ID_W-1:0]   alloc_id;
  logic              dealloc_req;
  logic [ID_W-1:0]   dealloc_id;
  logic              dealloc_ack;
  logic [ID_W:0]     count;
  logic              empty;
  logic              busy;

  modport slave (
    input  init_done,
    input  enq_req,
    input  enq_data,
    output enq_ack,
    input  deq_req,
    output deq_ack,
    output deq_data,
    output alloc_req,
    input  alloc_ack,
    input  alloc_id,
    output dealloc_req,
    output dealloc_id,
    input  dealloc_ack,
    output count,
    output empty,
    output busy
  );

  modport master (
    output init_done,
    output enq_req,
    output enq_data,
    input  enq_ack,
    output deq_req,
    input  deq_ack,
    input  deq_data,
    input  alloc_req,
    output alloc_ack,
    output alloc_id,
    input  dealloc_req,
    input  dealloc_id,
    output dealloc_ack,
    input  count,
    input  empty,
    input  busy
  );

endinterface

// File: rtl/llist_queue_ctrl_node_ram.sv
// Node storage: next-pointer lane and data lane per node.
// The next lane has an extra write enable for tail linking.
module llq_node_ram #(
  parameter int ID_W   = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ID_W-1:0]   waddr,
  input  logic [ID_W-1:0]   wnext,
  input  logic [DATA_W-1:0] wdata,
  input  logic              lwe,
  input  logic [ID_W-1:0]   laddr,
  input  logic [ID_W-1:0]   lnext,
  input  logic              re,
  input  logic [ID_W-1:0]   raddr,
  output logic [ID_W-1:0]   rnext,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ID_W;

  logic [ID_W-1:0]   next_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // laddr is the live tail, never the node being allocated
  always_ff @(posedge clk) begin
    if (we) next_mem[waddr] <= wnext;
    if (lwe) next_mem[laddr] <= lnext;
    if (re) rnext <= next_mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) data_mem[waddr] <= wdata;
    if (re) rdata <= data_mem[raddr];
  end

endmodule

// File: rtl/llist_queue_ctrl.sv
// Linked-list FIFO controller fed by the flist node allocator.
// Serialises enqueue/dequeue with round-robin tie breaking.
module llist_queue_ctrl
  import llq_pkg::*;
#(
  parameter int ID_W   = LLQ_ID_W,
  parameter int DATA_W = LLQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  llist_queue_ctrl_if.slave q
);

  localparam int CW = ID_W + 1;

  state_e            state_q, state_d;
  op_e               last_q, last_d;
  logic [ID_W-1:0]   head_q, head_d;
  logic [ID_W-1:0]   tail_q, tail_d;
  logic [ID_W-1:0]   dealloc_id_q, dealloc_id_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] deq_data_q, deq_data_d;
  logic              alloc_req_q, alloc_req_d;
  logic              dealloc_req_q, dealloc_req_d;
  logic              enq_ack_q, enq_ack_d;
  logic              deq_ack_q, deq_ack_d;
  logic              empty_q, empty_d;
  logic              busy_q, busy_d;

  logic              ram_we, ram_lwe, ram_re;
  logic [ID_W-1:0]   rd_next;
  logic [DATA_W-1:0] rd_data;

  logic not_empty;
  logic enq_ok, deq_ok;
  logic pick_enq, pick_deq;

  llq_node_ram #(
    .ID_W   (ID_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (q.alloc_id),
    .wnext ('0),
    .wdata (q.enq_data),
    .lwe   (ram_lwe),
    .laddr (tail_q),
    .lnext (q.alloc_id),
    .re    (ram_re),
    .raddr (head_q),
    .rnext (rd_next),
    .rdata (rd_data)
  );

  assign not_empty = (count_q != '0);
  assign enq_ok    = q.init_done & q.enq_req;
  assign deq_ok    = q.init_done & q.deq_req & not_empty;
  assign pick_enq  = enq_ok & (~deq_ok | (last_q == OP_DEQ));
  assign pick_deq  = deq_ok & ~pick_enq;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    dealloc_id_d  = dealloc_id_q;
    deq_data_d    = deq_data_q;
    alloc_req_d   = 1'b0;
    dealloc_req_d = 1'b0;
    enq_ack_d     = 1'b0;
    deq_ack_d     = 1'b0;
    ram_we        = 1'b0;
    ram_lwe       = 1'b0;
    ram_re        = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_enq: begin
            alloc_req_d = 1'b1;
            last_d      = OP_ENQ;
            state_d     = ALLOC_WAIT;
          end
          pick_deq: begin
            ram_re       = 1'b1;
            dealloc_id_d = head_q;
            last_d       = OP_DEQ;
            state_d      = DEQ_RD;
          end
          default: ;
        endcase
      end
      ALLOC_WAIT: begin
        if (q.alloc_ack) begin
          ram_we = 1'b1;
          // empty queue: new node becomes head, no link
          if (not_empty) ram_lwe = 1'b1;
          else head_d = q.alloc_id;
          tail_d    = q.alloc_id;
          count_d   = count_q + 1'b1;
          enq_ack_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DEQ_RD: begin
        deq_data_d    = rd_data;
        deq_ack_d     = 1'b1;
        head_d        = rd_next;
        count_d       = count_q - 1'b1;
        dealloc_req_d = 1'b1;
        state_d       = DEALLOC_WAIT;
      end
      DEALLOC_WAIT: begin
        if (q.dealloc_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    empty_d = (count_d == '0);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= OP_DEQ;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      dealloc_id_q  <= '0;
      deq_data_q    <= '0;
      alloc_req_q   <= 1'b0;
      dealloc_req_q <= 1'b0;
      enq_ack_q     <= 1'b0;
      deq_ack_q     <= 1'b0;
      empty_q       <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      dealloc_id_q  <= dealloc_id_d;
      deq_data_q    <= deq_data_d;
      alloc_req_q   <= alloc_req_d;
      dealloc_req_q <= dealloc_req_d;
      enq_ack_q     <= enq_ack_d;
      deq_ack_q     <= deq_ack_d;
      empty_q       <= empty_d;
      busy_q        <= busy_d;
    end
  end

  assign q.alloc_req   = alloc_req_q;
  assign q.dealloc_req = dealloc_req_q;
  assign q.dealloc_id  = dealloc_id_q;
  assign q.enq_ack     = enq_ack_q;
  assign q.deq_ack     = deq_ack_q;
  assign q.deq_data    = deq_data_q;
  assign q.count       = count_q;
  assign q.empty       = empty_q;
  assign q.busy        = busy_q;

endmodule

// File: tb/tb_llist_queue_ctrl.sv
// Bench for llist_queue_ctrl with an flist model and scoreboard.
// Small ID_W so the free list can be exhausted.
module tb_llist_queue_ctrl;
  import llq_pkg::*;

  localparam int ID_W   = 3;
  localparam int DATA_W = 16;
  localparam int NODES  = 1 << ID_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  llist_queue_ctrl_if #(.ID_W(ID_W), .DATA_W(DATA_W)) q_if ();

  llist_queue_ctrl #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q_if)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ---------------- flist model ----------------
  logic [ID_W-1:0] pool [NODES];
  int              pool_rd, pool_cnt;
  bit              a_pend, d_pend;
  int              a_dly, d_dly;
  logic [ID_W-1:0] d_id, last_grant;
  int              dly_lo = 0;
  int              dly_hi = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_if.alloc_ack   = 1'b0;
      q_if.dealloc_ack = 1'b0;
      q_if.alloc_id    = '0;
      a_pend   = 0;
      d_pend   = 0;
      pool_rd  = 0;
      pool_cnt = NODES;
      for (int i = 0; i < NODES; i++)
        pool[i] = ID_W'((i * 5 + 5) % NODES);
    end else begin
      q_if.alloc_ack   = 1'b0;
      q_if.dealloc_ack = 1'b0;
      if (d_pend)
        check("dealloc_id_stable", 64'(q_if.dealloc_id), 64'(d_id));
      if (q_if.dealloc_req) begin
        d_pend = 1;
        d_id   = q_if.dealloc_id;
        d_dly  = $urandom_range(dly_hi, dly_lo);
      end
      if (d_pend) begin
        if (d_dly == 0) begin
          pool[(pool_rd + pool_cnt) % NODES] = d_id;
          pool_cnt++;
          q_if.dealloc_ack = 1'b1;
          d_pend = 0;
        end else d_dly--;
      end
      if (q_if.alloc_req) begin
        a_pend = 1;
        a_dly  = $urandom_range(dly_hi, dly_lo);
      end
      if (a_pend) begin
        if (a_dly > 0) a_dly--;
        else if (pool_cnt > 0) begin
          q_if.alloc_id  = pool[pool_rd];
          q_if.alloc_ack = 1'b1;
          last_grant     = pool[pool_rd];
          pool_rd        = (pool_rd + 1) % NODES;
          pool_cnt--;
          a_pend = 0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [DATA_W-1:0] exp_data [$];
  logic [ID_W-1:0]   exp_id [$];
  byte               op_log [$];
  int                model_cnt = 0;
  int                n_enq_ack = 0;
  int                n_deq_ack = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (q_if.enq_ack) begin
        n_enq_ack++;
        model_cnt++;
        exp_id.push_back(last_grant);
        op_log.push_back("E");
        check("enq_count", 64'(q_if.count), 64'(model_cnt));
        check("enq_empty", 64'(q_if.empty), 64'(model_cnt == 0));
      end
      if (q_if.deq_ack) begin
        n_deq_ack++;
        model_cnt--;
        op_log.push_back("D");
        if (exp_data.size() == 0) fail_now("deq_data unexpected dequeue");
        else check("deq_data", 64'(q_if.deq_data), 64'(exp_data.pop_front()));
        check("deq_count", 64'(q_if.count), 64'(model_cnt));
        check("deq_empty", 64'(q_if.empty), 64'(model_cnt == 0));
      end
      if (q_if.dealloc_req) begin
        if (exp_id.size() == 0) fail_now("dealloc_id unexpected free");
        else check("dealloc_id", 64'(q_if.dealloc_id), 64'(exp_id.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_enq(input logic [DATA_W-1:0] d, output int cyc);
    bit got;
    got = 0;
    cyc = 0;
    q_if.enq_data = d;
    q_if.enq_req  = 1'b1;
    exp_data.push_back(d);
    for (int i = 1; i <= 3000 && !got; i++) begin
      @(negedge clk);
      if (q_if.enq_ack) begin
        got = 1;
        cyc = i;
      end
    end
    q_if.enq_req = 1'b0;
    if (!got) fail_now($sformatf("enq_timeout data %0h: no ack in 3000 cycles", d));
  endtask

  task automatic do_deq(output int cyc);
    bit got;
    got = 0;
    cyc = 0;
    q_if.deq_req = 1'b1;
    for (int i = 1; i <= 3000 && !got; i++) begin
      @(negedge clk);
      if (q_if.deq_ack) begin
        got = 1;
        cyc = i;
      end
    end
    q_if.deq_req = 1'b0;
    if (!got) fail_now("deq_timeout: no ack in 3000 cycles");
  endtask

  task automatic reset_and_check(input string name);
    #1 rst_n = 1'b0;
    q_if.enq_req = 1'b0;
    q_if.deq_req = 1'b0;
    #1;
    check(name,
          {q_if.alloc_req, q_if.dealloc_req, q_if.dealloc_id, q_if.enq_ack,
           q_if.deq_ack, q_if.deq_data, q_if.count, q_if.empty, q_if.busy},
          {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    exp_data.delete();
    exp_id.delete();
    model_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c, c2, base, occ, op;
    bit seen;
    string exp_s;
    logic [DATA_W-1:0] d;

    q_if.init_done = 1'b0;
    q_if.enq_req   = 1'b0;
    q_if.enq_data  = '0;
    q_if.deq_req   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {q_if.alloc_req, q_if.dealloc_req, q_if.dealloc_id, q_if.enq_ack,
           q_if.deq_ack, q_if.deq_data, q_if.count, q_if.empty, q_if.busy},
          {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0});
    rst_n = 1'b1;

    // no service before flist is ready
    q_if.enq_req = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (q_if.alloc_req || q_if.busy) seen = 1;
    end
    check("no_serve_before_init", 64'(seen), 64'(0));
    q_if.enq_req   = 1'b0;
    q_if.init_done = 1'b1;
    @(negedge clk);

    // basic order
    do_enq(16'h1111, c);
    check("enq_latency", 64'(c), 64'(2));
    do_enq(16'h2222, c);
    do_enq(16'h3333, c);
    @(negedge clk);
    check("count_after_3", 64'(q_if.count), 64'(3));
    do_deq(c);
    check("deq_latency", 64'(c), 64'(2));
    do_deq(c);
    do_deq(c);

    // dequeue while empty waits for a later enqueue
    @(negedge clk);
    fork
      do_deq(c);
      begin
        base = n_deq_ack;
        repeat (50) @(negedge clk);
        check("empty_deq_no_ack", 64'(n_deq_ack - base), 64'(0));
        do_enq(16'hABCD, c2);
      end
    join
    @(negedge clk);

    // round-robin under contention, starting after a dequeue
    do_enq(16'hA001, c);
    do_enq(16'hA002, c);
    do_enq(16'hA003, c);
    do_deq(c);
    @(negedge clk);
    base = op_log.size();
    fork
      begin
        do_enq(16'hB001, c);
        do_enq(16'hB002, c);
      end
      do_deq(c2);
    join
    @(negedge clk);
    exp_s = "EDE";
    check("alt_log_len", 64'(op_log.size() - base), 64'(3));
    for (int k = 0; k < 3; k++)
      if (base + k < op_log.size())
        check($sformatf("alt_order_%0d", k), 64'(op_log[base + k]), 64'(exp_s[k]));

    // fill the free list
    for (int k = 0; k < 5; k++) do_enq(16'hC000 + 16'(k), c);
    @(negedge clk);
    check("count_full", 64'(q_if.count), 64'(NODES));
    base = op_log.size();
    fork
      do_enq(16'hC0FF, c);
      do_deq(c2);
    join
    @(negedge clk);
    exp_s = "DE";
    check("recycle_log_len", 64'(op_log.size() - base), 64'(2));
    for (int k = 0; k < 2; k++)
      if (base + k < op_log.size())
        check($sformatf("recycle_order_%0d", k), 64'(op_log[base + k]), 64'(exp_s[k]));
    check("count_full_again", 64'(q_if.count), 64'(NODES));

    // exhausted: enqueue sits in ALLOC_WAIT, then reset there
    q_if.enq_data = 16'hDEAD;
    q_if.enq_req  = 1'b1;
    base = n_enq_ack;
    repeat (30) @(negedge clk);
    check("full_stall_no_ack", 64'(n_enq_ack - base), 64'(0));
    check("full_stall_busy", 64'(q_if.busy), 64'(1));
    reset_and_check("reset_in_alloc_wait");
    do_enq(16'h5A5A, c);
    check("post_rst1_enq_lat", 64'(c), 64'(2));
    do_deq(c);
    check("post_rst1_deq_lat", 64'(c), 64'(2));

    // reset while the freed node awaits its ack
    do_enq(16'h7E7E, c);
    dly_lo = 10;
    dly_hi = 10;
    do_deq(c);
    repeat (3) @(negedge clk);
    check("dealloc_wait_busy", 64'(q_if.busy), 64'(1));
    reset_and_check("reset_in_dealloc_wait");
    dly_lo = 0;
    dly_hi = 0;
    do_enq(16'h0F0F, c);
    check("post_rst2_enq_lat", 64'(c), 64'(2));
    do_deq(c);
    check("post_rst2_deq_lat", 64'(c), 64'(2));

    // mixed traffic with random flist latency
    dly_hi = 20;
    occ = 0;
    for (int k = 0; k < 1500; k++) begin
      op = $urandom_range(2, 0);
      if (occ == 0) op = 0;
      else if (occ == NODES) op = 1;
      d = 16'($urandom);
      case (op)
        0: begin do_enq(d, c); occ++; end
        1: begin do_deq(c); occ--; end
        default: fork
          do_enq(d, c);
          do_deq(c2);
        join
      endcase
    end
    repeat (30) @(negedge clk);
    check("final_count", 64'(q_if.count), 64'(occ));
    check("final_sb_depth", 64'(exp_data.size()), 64'(occ));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
